// File: rtl/mem_stall_responder_pkg.sv
// rtl/mem_stall_responder_pkg.sv - shared FSM encodings and sizing constants for the MEM-stage responder
package mem_stall_responder_pkg;

    // Responder FSM states; encodings are visible to the CPU top's debug taps
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Defaults shared with the CPU top so its stall sizing matches the responder
    localparam int DEFAULT_LATENCY   = 4;
    localparam int DEFAULT_NUM_WORDS = 1024;

    // Width of the latency down-counter; covers LATENCY up to 15
    localparam int CNT_W = 4;

    // Counter preload: the accept edge itself is the first of LATENCY cycles
    function automatic logic [CNT_W-1:0] latency_load_value(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_stall_responder_if.sv
// rtl/mem_stall_responder_if.sv - request/response bus between MEM stage and data memory responder
interface mem_stall_responder_if;

    logic        is_input_valid;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] din;
    logic        is_ready;
    logic        is_output_valid;
    logic [31:0] dout;

    // Requester side (pipeline MEM stage)
    modport master (
        output is_input_valid,
        output mem_read,
        output mem_write,
        output addr,
        output din,
        input  is_ready,
        input  is_output_valid,
        input  dout
    );

    // Responder side (data memory)
    modport slave (
        input  is_input_valid,
        input  mem_read,
        input  mem_write,
        input  addr,
        input  din,
        output is_ready,
        output is_output_valid,
        output dout
    );

endinterface

// File: rtl/mem_latency_counter.sv
// rtl/mem_latency_counter.sv - 4-bit loadable down-counter timing the responder's busy window
module mem_latency_counter
    import mem_stall_responder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // Load wins over decrement; counting stops at zero so an idle counter never wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Done one cycle early: the state change to RESP consumes the final count
    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mem_stall_responder.sv
// rtl/mem_stall_responder.sv - fixed-latency data memory responder; ZERO_WAIT_WRITE_EN selects single-edge stores
module mem_stall_responder
    import mem_stall_responder_pkg::*;
#(
    parameter int LATENCY   = DEFAULT_LATENCY,
    parameter int NUM_WORDS = DEFAULT_NUM_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_stall_responder_if.slave  bus
);

    localparam int               IDX_W        = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LOAD_VAL     = latency_load_value(LATENCY);
    localparam bit               SINGLE_CYCLE = (LATENCY == 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_din;
    logic             r_is_store;
    logic [31:0]      r_dout;
    logic [31:0]      r_mem [NUM_WORDS];

    logic [IDX_W-1:0] w_in_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_in_store;
    logic             w_rd_is_store;
    logic             w_accept;
    logic             w_go;
    logic             w_direct_commit;
    logic             w_commit;
    logic             w_cnt_en;
    logic             w_cnt_done;
    logic             w_ready;
    logic             w_out_valid;
    logic             w_load_dout;
    logic             w_unused_addr;

    // Word index drops byte offset and any address bits above the array
    assign w_in_idx      = bus.addr[2 +: IDX_W];
    assign w_unused_addr = ^{bus.addr[1:0], bus.addr[31:2+IDX_W]};

    // Write bit dominates, so read+write together behaves as a store
    assign w_in_store = bus.mem_write;
    assign w_accept   = (r_state == ST_IDLE) && bus.is_input_valid
                        && (bus.mem_read || bus.mem_write);

`ifdef ZERO_WAIT_WRITE_EN
    assign w_go            = w_accept && !w_in_store;
    assign w_direct_commit = w_accept && w_in_store;
`else
    assign w_go            = w_accept;
    assign w_direct_commit = 1'b0;
`endif

    // Latched store retires on the RESP edge, before the responder reports ready again
    assign w_commit = (r_state == ST_RESP) && r_is_store;
    assign w_cnt_en = (r_state == ST_BUSY);

    mem_latency_counter u_latency_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_go),
        .i_load_val (LOAD_VAL),
        .i_en       (w_cnt_en),
        .o_done     (w_cnt_done)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and state-decoded handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (w_go) begin
                    w_next_state = SINGLE_CYCLE ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_cnt_done) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_out_valid  = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Capture the request on accept so the bus can move on while we are busy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_din      <= '0;
            r_is_store <= 1'b0;
        end else if (w_go) begin
            r_idx      <= w_in_idx;
            r_din      <= bus.din;
            r_is_store <= w_in_store;
        end
    end

    // With LATENCY==1 RESP follows the accept edge directly, so read from the live request
    assign w_rd_idx      = (r_state == ST_IDLE) ? w_in_idx   : r_idx;
    assign w_rd_is_store = (r_state == ST_IDLE) ? w_in_store : r_is_store;
    assign w_load_dout   = (w_next_state == ST_RESP) && (r_state != ST_RESP) && !w_rd_is_store;

    // Load data registered on entry to RESP and held until the next load response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= '0;
        end else if (w_load_dout) begin
            r_dout <= r_mem[w_rd_idx];
        end
    end

    // Array is never cleared; reset suppresses a pending store commit
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_commit) begin
                r_mem[r_idx] <= r_din;
            end else if (w_direct_commit) begin
                r_mem[w_in_idx] <= bus.din;
            end
        end
    end

    assign bus.is_ready        = w_ready;
    assign bus.is_output_valid = w_out_valid;
    assign bus.dout            = r_dout;

endmodule

// File: doc/mem_stall_responder.md
# mem_stall_responder

Multi-cycle data-memory responder for the pipelined CPU's MEM stage. Accepts one load or store request at a time over a valid/ready handshake. It returns load data after a fixed LATENCY, and holds is_ready low while busy. The pipeline's hazard logic therefore sees the stall from the memory end and freezes PC, IF/ID, ID/EX and EX/MEM until the response arrives.

## Interface
- LATENCY, 4: cycles from request accept to response; legal range 1..15
- NUM_WORDS, 1024: 32-bit words in the array; power of two
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- is_input_valid  input  1  request present this cycle
- mem_read  input  1  request is a load
- mem_write  input  1  request is a store
- addr  input  32  byte address; bits [1:0] ignored
- din  input  32  store data
- is_ready  output  1  responder can accept a request this cycle
- is_output_valid  output  1  one-cycle response pulse
- dout  output  32  load data, valid when is_output_valid && load

## Operation
- Word index = addr[2 +: log2(NUM_WORDS)]. Upper address bits are dropped, so addresses wrap modulo the array size.
- FSM states:
  - IDLE: is_ready=1.
  - BUSY: wait counter running; is_ready=0.
  - RESP: is_ready=0, is_output_valid=1.
- Accept occurs in IDLE when is_input_valid && (mem_read || mem_write).
  - At the accept edge, latch addr, din and the op.
  - Load cnt = LATENCY-1.
  - Go to BUSY, or straight to RESP if LATENCY==1.
- BUSY: cnt decrements each cycle; when cnt==1, next state is RESP.
- RESP:
  - Load: dout = mem[latched index].
  - Store: commits mem[latched index] = latched din at the RESP edge; dout unchanged.
  - Next state is IDLE.
- mem_read && mem_write both high: treated as a store.
- is_input_valid with neither op bit set: ignored; stays IDLE.
- Inputs while not IDLE: ignored. The requester must hold the request until it sees is_ready.
- dout holds the last load value between responses.
- Reset values: state=IDLE, cnt=0, is_ready=1, is_output_valid=0, dout=0. Array contents are not cleared.
- Reset during BUSY/RESP: returns to IDLE; a pending store is discarded (not committed).

## Timing
- Request accepted at the end of cycle N.
- is_ready=0 in cycles N+1 .. N+LATENCY.
- is_output_valid=1 in cycle N+LATENCY only.
- is_ready=1 again in cycle N+LATENCY+1; earliest next accept is at the end of that cycle.
- Throughput: one request per LATENCY+1 cycles.
- is_ready and is_output_valid are registered-state decodes with no combinational path from inputs.
- A load issued right after a store to the same word returns the stored value, because the store commits before IDLE.

## Configuration
- ZERO_WAIT_WRITE_EN defined:
  - Stores commit at the accept edge; FSM stays IDLE and is_ready stays 1.
  - No is_output_valid pulse for stores.
  - Loads unchanged.
- ZERO_WAIT_WRITE_EN undefined: stores follow the full LATENCY path and pulse is_output_valid as above.

## Structure
- Shared package:
  - FSM state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2).
  - Default LATENCY and NUM_WORDS constants, shared with the CPU top for stall sizing.
- One sub-module: mem_latency_counter.
  - 4-bit down-counter with load/enable and a done flag.
  - Instantiated once; FSM and array stay in the top.

## Test plan
- Reset, then load from addr 0x10 after preloading mem[4]=0xDEADBEEF, LATENCY=4 -> is_ready low for 4 cycles, is_output_valid high exactly in cycle 4 after accept, dout=0xDEADBEEF.
- Store 0x12345678 to 0x20, then load 0x20 at the first ready cycle -> load returns 0x12345678. Without the macro the store pulses is_output_valid; with ZERO_WAIT_WRITE_EN, is_ready never drops on the store.
- New request driven while BUSY (load 0x40 during a pending load 0x10) -> ignored; response carries mem[4] data; the 0x40 request is accepted only after is_ready returns.
- Store to 0x24, reset asserted one cycle after accept, then load 0x24 -> old contents returned; outputs zero during and after reset.
- LATENCY=1 load -> is_output_valid in the cycle right after accept. Address 0x1000 + 0x8 with NUM_WORDS=1024 -> wraps to mem[2].
- Request with mem_read=mem_write=1 and din=0xA5A5A5A5 to 0x30 -> treated as a store; a subsequent load 0x30 returns 0xA5A5A5A5.
